// File: rtl/ram_2p_pipe_pkg.sv
// Shared types and helpers for the dual-port RAM and its response pipelines.
// Response words are carried at the widest supported width; unused upper bits are zero.
package ram_pkg;

   localparam int MaxReadLatency = 4;
   localparam int MaxDataWidth   = 64;

   typedef struct packed {
      logic                    valid;
      logic                    err;
      logic [MaxDataWidth-1:0] rdata;
   } ram_rsp_t;

   function automatic int ram_idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ram_2p_pipe_if.sv
// One RAM port: request (always accepted, no stall) plus the delayed response.
// The master drives requests; the slave (the RAM) drives rvalid/rdata/err.
interface ram_2p_pipe_if #(
   parameter int DataWidth = 32
);
   logic                   req;
   logic                   we;
   logic [DataWidth/8-1:0] be;
   logic [31:0]            addr;
   logic [DataWidth-1:0]   wdata;
   logic                   rvalid;
   logic [DataWidth-1:0]   rdata;
   logic                   err;

   modport master (
      output req, we, be, addr, wdata,
      input  rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output rvalid, rdata, err
   );
endinterface

// File: rtl/ram_rsp_pipe.sv
// Response delay line: ReadLatency register stages, no stall (full throughput).
// Reset clears every stage so in-flight responses are dropped, never emitted.
module ram_rsp_pipe
   import ram_pkg::*;
#(
   parameter int ReadLatency = 1
) (
   input  logic     CLK,
   input  logic     RST_N,
   input  ram_rsp_t rsp_d,
   output ram_rsp_t rsp_q
);

   ram_rsp_t stage_q [ReadLatency];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < ReadLatency; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= rsp_d;
         for (int i = 1; i < ReadLatency; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign rsp_q = stage_q[ReadLatency-1];

endmodule

// File: rtl/ram_2p_pipe.sv
// True dual-port byte-enabled RAM; array access in the request cycle, response after ReadLatency cycles.
// No backpressure. Optional collision counter under RAM_2P_PIPE_COLLISION_CNT_EN.
module ram_2p_pipe
   import ram_pkg::*;
#(
   parameter int    Depth       = 128,
   parameter int    DataWidth   = 32,
   parameter int    ReadLatency = 1,
   parameter string MemInitFile = ""
) (
   input  logic         CLK,
   input  logic         RST_N,
   ram_2p_pipe_if.slave a_if,
   ram_2p_pipe_if.slave b_if,
`ifdef RAM_2P_PIPE_COLLISION_CNT_EN
   input  logic         collision_clr_i,
   output logic [15:0]  collision_cnt_o,
`endif
   output logic         collision_o
);

   localparam int          NumBytes = DataWidth / 8;
   localparam int          Ow       = $clog2(NumBytes);
   localparam int          Aw       = ram_idx_width(Depth);
   localparam logic [32:0] MemBytes = 33'(Depth * NumBytes);

   logic [DataWidth-1:0] mem [Depth];

   logic [Aw-1:0] a_idx, b_idx;
   logic          a_ok, b_ok;
   logic          a_wr, b_wr;
   ram_rsp_t      a_rsp_d, b_rsp_d;
   ram_rsp_t      a_rsp_q, b_rsp_q;

   assign a_idx = a_if.addr[Aw+Ow-1:Ow];
   assign b_idx = b_if.addr[Aw+Ow-1:Ow];
   assign a_ok  = {1'b0, a_if.addr} < MemBytes;
   assign b_ok  = {1'b0, b_if.addr} < MemBytes;
   assign a_wr  = a_if.req & a_if.we & a_ok;
   assign b_wr  = b_if.req & b_if.we & b_ok;

   // Reads see the array before this cycle's writes land: read-first on both ports.
   always_comb begin
      a_rsp_d       = '0;
      a_rsp_d.valid = a_if.req;
      a_rsp_d.err   = a_if.req & ~a_ok;
      if (a_if.req && !a_if.we && a_ok) begin
         a_rsp_d.rdata = MaxDataWidth'(mem[a_idx]);
      end
   end

   always_comb begin
      b_rsp_d       = '0;
      b_rsp_d.valid = b_if.req;
      b_rsp_d.err   = b_if.req & ~b_ok;
      if (b_if.req && !b_if.we && b_ok) begin
         b_rsp_d.rdata = MaxDataWidth'(mem[b_idx]);
      end
   end

   // Port A's byte writes are issued after port B's, so A owns bytes both ports enable.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NumBytes; i++) begin
         if (b_wr && b_if.be[i]) begin
            mem[b_idx][i*8 +: 8] <= b_if.wdata[i*8 +: 8];
         end
         if (a_wr && a_if.be[i]) begin
            mem[a_idx][i*8 +: 8] <= a_if.wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         collision_o <= 1'b0;
      end else begin
         collision_o <= a_wr & b_wr & (a_idx == b_idx);
      end
   end

`ifdef RAM_2P_PIPE_COLLISION_CNT_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         collision_cnt_o <= '0;
      end else if (collision_clr_i) begin
         collision_cnt_o <= '0;
      end else if (collision_o && (collision_cnt_o != 16'hFFFF)) begin
         collision_cnt_o <= collision_cnt_o + 16'd1;
      end
   end
`endif

   ram_rsp_pipe #(
      .ReadLatency (ReadLatency)
   ) u_a_pipe (
      .CLK   (CLK),
      .RST_N (RST_N),
      .rsp_d (a_rsp_d),
      .rsp_q (a_rsp_q)
   );

   ram_rsp_pipe #(
      .ReadLatency (ReadLatency)
   ) u_b_pipe (
      .CLK   (CLK),
      .RST_N (RST_N),
      .rsp_d (b_rsp_d),
      .rsp_q (b_rsp_q)
   );

   assign a_if.rvalid = a_rsp_q.valid;
   assign a_if.err    = a_rsp_q.err;
   assign a_if.rdata  = a_rsp_q.rdata[DataWidth-1:0];
   assign b_if.rvalid = b_rsp_q.valid;
   assign b_if.err    = b_rsp_q.err;
   assign b_if.rdata  = b_rsp_q.rdata[DataWidth-1:0];

   logic unused_rsp_hi;
   assign unused_rsp_hi = ^{a_rsp_q.rdata, b_rsp_q.rdata};

   a_req_known: assert property (@(posedge CLK) disable iff (!RST_N) !$isunknown(a_if.req));
   b_req_known: assert property (@(posedge CLK) disable iff (!RST_N) !$isunknown(b_if.req));

endmodule

// File: tb/tb_ram_2p_pipe.sv
// Directed plus random test of ram_2p_pipe against a byte-array memory model
// with a per-port queue of expected responses keyed by due cycle.
module tb_ram_2p_pipe;

   localparam int Depth    = 128;
   localparam int DW       = 32;
   localparam int NB       = DW / 8;
   localparam int LAT      = 3;
   localparam int MemBytes = Depth * NB;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic collision;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   ram_2p_pipe_if #(.DataWidth(DW)) a_if ();
   ram_2p_pipe_if #(.DataWidth(DW)) b_if ();

`ifdef RAM_2P_PIPE_COLLISION_CNT_EN
   logic        coll_clr = 1'b0;
   logic [15:0] coll_cnt;
`endif

   ram_2p_pipe #(
      .Depth       (Depth),
      .DataWidth   (DW),
      .ReadLatency (LAT),
      .MemInitFile ("")
   ) dut (
      .CLK             (CLK),
      .RST_N           (RST_N),
      .a_if            (a_if),
      .b_if            (b_if),
`ifdef RAM_2P_PIPE_COLLISION_CNT_EN
      .collision_clr_i (coll_clr),
      .collision_cnt_o (coll_cnt),
`endif
      .collision_o     (collision)
   );

   typedef struct {
      int            due;
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   logic [7:0]    mdl [MemBytes];
   exp_t          qa[$];
   exp_t          qb[$];
   int            coll_due[$];
   logic [DW-1:0] a_last, b_last;
   logic          a_last_err, b_last_err;
   int            a_seen = 0, b_seen = 0, coll_seen = 0, coll_model = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mdl_word(input logic [31:0] addr);
      logic [DW-1:0] w;
      int base;
      base = int'(addr / NB) * NB;
      for (int k = 0; k < NB; k++) w[k*8 +: 8] = mdl[base + k];
      return w;
   endfunction

   task automatic mdl_write(input logic [31:0] addr, input logic [NB-1:0] be, input logic [DW-1:0] wd);
      int base;
      base = int'(addr / NB) * NB;
      for (int k = 0; k < NB; k++) if (be[k]) mdl[base + k] = wd[k*8 +: 8];
   endtask

   task automatic check_outputs();
      exp_t e;
      if (qa.size() > 0 && qa[0].due == cyc) begin
         e = qa.pop_front();
         chkb("a_rvalid", a_if.rvalid, 1'b1);
         chkb("a_err", a_if.err, e.err);
         chk("a_rdata", a_if.rdata, e.data);
         a_last = a_if.rdata;
         a_last_err = a_if.err;
      end else begin
         chkb("a_rvalid_idle", a_if.rvalid, 1'b0);
      end
      if (a_if.rvalid) a_seen++;
      if (qb.size() > 0 && qb[0].due == cyc) begin
         e = qb.pop_front();
         chkb("b_rvalid", b_if.rvalid, 1'b1);
         chkb("b_err", b_if.err, e.err);
         chk("b_rdata", b_if.rdata, e.data);
         b_last = b_if.rdata;
         b_last_err = b_if.err;
      end else begin
         chkb("b_rvalid_idle", b_if.rvalid, 1'b0);
      end
      if (b_if.rvalid) b_seen++;
      if (coll_due.size() > 0 && coll_due[0] == cyc) begin
         void'(coll_due.pop_front());
         chkb("collision", collision, 1'b1);
      end else begin
         chkb("collision_idle", collision, 1'b0);
      end
      if (collision) coll_seen++;
   endtask

   // Called at a falling edge: check what is due now, present the next request, advance one cycle.
   task automatic step(input logic ar, input logic aw, input logic [NB-1:0] abe,
                       input logic [31:0] aad, input logic [DW-1:0] awd,
                       input logic br, input logic bw, input logic [NB-1:0] bbe,
                       input logic [31:0] bad, input logic [DW-1:0] bwd);
      logic a_ok, b_ok;
      check_outputs();
      a_if.req = ar; a_if.we = aw; a_if.be = abe; a_if.addr = aad; a_if.wdata = awd;
      b_if.req = br; b_if.we = bw; b_if.be = bbe; b_if.addr = bad; b_if.wdata = bwd;
      if (RST_N) begin
         a_ok = aad < 32'(MemBytes);
         b_ok = bad < 32'(MemBytes);
         if (ar) qa.push_back('{cyc + LAT, !a_ok, (!aw && a_ok) ? mdl_word(aad) : {DW{1'b0}}});
         if (br) qb.push_back('{cyc + LAT, !b_ok, (!bw && b_ok) ? mdl_word(bad) : {DW{1'b0}}});
         if (ar && aw && a_ok && br && bw && b_ok && (aad / NB) == (bad / NB)) begin
            coll_due.push_back(cyc + 1);
            coll_model++;
         end
         if (br && bw && b_ok) mdl_write(bad, bbe, bwd);
         if (ar && aw && a_ok) mdl_write(aad, abe, awd);
      end
      @(negedge CLK);
   endtask

   task automatic idle();
      step('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic wr_a(input logic [31:0] ad, input logic [NB-1:0] be, input logic [DW-1:0] wd);
      step(1'b1, 1'b1, be, ad, wd, '0, '0, '0, '0, '0);
   endtask

   task automatic rd_a(input logic [31:0] ad);
      step(1'b1, 1'b0, '0, ad, '0, '0, '0, '0, '0, '0);
   endtask

   task automatic wr_b(input logic [31:0] ad, input logic [NB-1:0] be, input logic [DW-1:0] wd);
      step('0, '0, '0, '0, '0, 1'b1, 1'b1, be, ad, wd);
   endtask

   task automatic rd_b(input logic [31:0] ad);
      step('0, '0, '0, '0, '0, 1'b1, 1'b0, '0, ad, '0);
   endtask

   task automatic drain();
      repeat (LAT + 1) idle();
   endtask

   task automatic assert_reset();
      RST_N = 1'b0;
      qa.delete();
      qb.delete();
      coll_due.delete();
      coll_model = 0;
   endtask

   initial begin
      int as, cs;
      a_if.req = 1'b0; a_if.we = 1'b0; a_if.be = '0; a_if.addr = '0; a_if.wdata = '0;
      b_if.req = 1'b0; b_if.we = 1'b0; b_if.be = '0; b_if.addr = '0; b_if.wdata = '0;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chkb("rst_a_rvalid", a_if.rvalid, 1'b0);
      chkb("rst_a_err", a_if.err, 1'b0);
      chk("rst_a_rdata", a_if.rdata, '0);
      chkb("rst_b_rvalid", b_if.rvalid, 1'b0);
      chkb("rst_b_err", b_if.err, 1'b0);
      chk("rst_b_rdata", b_if.rdata, '0);
      chkb("rst_collision", collision, 1'b0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Give every word a known value so random reads have a defined expectation.
      for (int i = 0; i < Depth / 2; i++) begin
         step(1'b1, 1'b1, '1, 32'(i * NB), $urandom(),
              1'b1, 1'b1, '1, 32'((i + Depth / 2) * NB), $urandom());
      end
      drain();

      wr_a(32'h10, 4'hF, 32'hDEADBEEF);
      a_last = 'x;
      rd_a(32'h10);
      drain();
      chk("basic_rdata", a_last, 32'hDEADBEEF);
      chkb("basic_err", a_last_err, 1'b0);

      wr_a(32'h40, 4'hF, 32'h11223344);
      wr_b(32'h40, 4'b0101, 32'hAABBCCDD);
      b_last = 'x;
      rd_b(32'h40);
      drain();
      chk("partial_rdata", b_last, 32'h11BB33DD);

      wr_a(32'h20, 4'hF, 32'h0);
      cs = coll_seen;
      step(1'b1, 1'b1, 4'b0011, 32'h20, 32'h000000FF, 1'b1, 1'b1, 4'b0110, 32'h20, 32'hFFFF0000);
      idle();
      idle();
      chk("collision_pulses", 32'(coll_seen - cs), 32'd1);
      a_last = 'x;
      rd_a(32'h20);
      drain();
      chk("collision_merge", a_last, 32'h00FF00FF);

      wr_a(32'h30, 4'hF, 32'h12345678);
      a_last = 'x;
      step(1'b1, 1'b0, '0, 32'h30, '0, 1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
      drain();
      chk("read_first_old", a_last, 32'h12345678);
      a_last = 'x;
      rd_a(32'h30);
      drain();
      chk("read_first_new", a_last, 32'hCAFEF00D);

      wr_a(32'h0, 4'hF, 32'h5A5A5A5A);
      a_last = 'x;
      rd_a(32'h200);
      drain();
      chk("oor_rdata", a_last, 32'h0);
      chkb("oor_err", a_last_err, 1'b1);
      wr_a(32'h200, 4'hF, 32'hFFFFFFFF);
      a_last = 'x;
      rd_a(32'h0);
      drain();
      chk("oor_write_dropped", a_last, 32'h5A5A5A5A);

      // Reset lands while a read and a write are still in flight.
      as = a_seen;
      rd_a(32'h10);
      wr_a(32'h50, 4'hF, 32'h0BADF00D);
      assert_reset();
      rd_a(32'h20);
      rd_a(32'h30);
      idle();
      RST_N = 1'b1;
      repeat (LAT + 3) idle();
      chk("reset_pulses", 32'(a_seen - as), 32'd0);
      a_last = 'x;
      rd_a(32'h50);
      drain();
      chk("write_persists", a_last, 32'h0BADF00D);

      as = a_seen;
      rd_a(32'h13);
      rd_a(32'h40);
      rd_a(32'h20);
      rd_a(32'h30);
      drain();
      chk("b2b_pulses", 32'(a_seen - as), 32'd4);
      chk("b2b_last", a_last, 32'hCAFEF00D);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] aa, ba;
         logic        ar, br;
         aa = $urandom_range(0, MemBytes + 63);
         ba = ($urandom_range(0, 3) == 0) ? (aa ^ 32'($urandom_range(0, 3)))
                                          : $urandom_range(0, MemBytes + 63);
         ar = ($urandom_range(0, 3) != 0);
         br = ($urandom_range(0, 3) != 0);
         step(ar, 1'($urandom_range(0, 1)), NB'($urandom()), aa, $urandom(),
              br, 1'($urandom_range(0, 1)), NB'($urandom()), ba, $urandom());
      end
      drain();

`ifdef RAM_2P_PIPE_COLLISION_CNT_EN
      chk("coll_cnt", 32'(coll_cnt), 32'(coll_model));
      coll_clr = 1'b1;
      idle();
      coll_clr = 1'b0;
      chk("coll_cnt_clr", 32'(coll_cnt), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
